// File: rtl/axi_write_splitter_if.sv
// Bus bundle for axi_write_splitter: merged upstream beat stream, upstream
// response, and the downstream AXI4 AW/W/B channels.
//   master : splitter view (it masters the AXI write port)
//   slave  : environment view (upstream initiator + downstream memory side)
interface axi_write_splitter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  s_valid;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [ID_WIDTH-1:0]   s_id;
    logic [1:0]            s_burst;
    logic [2:0]            s_size;
    logic [7:0]            s_len;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [STRB_WIDTH-1:0] s_wstrb;
    logic                  s_wlast;

    logic                  s_bvalid;
    logic                  s_bready;
    logic [1:0]            s_bresp;
    logic [ID_WIDTH-1:0]   s_bid;

    logic                  m_awvalid;
    logic                  m_awready;
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [ID_WIDTH-1:0]   m_awid;
    logic [1:0]            m_awburst;
    logic [2:0]            m_awsize;
    logic [7:0]            m_awlen;

    logic                  m_wvalid;
    logic                  m_wready;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [STRB_WIDTH-1:0] m_wstrb;
    logic                  m_wlast;

    logic                  m_bvalid;
    logic                  m_bready;
    logic [1:0]            m_bresp;
    logic [ID_WIDTH-1:0]   m_bid;

    modport master (
        input  s_valid, s_addr, s_id, s_burst, s_size, s_len, s_wdata, s_wstrb, s_wlast,
        output s_ready,
        output s_bvalid, s_bresp, s_bid,
        input  s_bready,
        output m_awvalid, m_awaddr, m_awid, m_awburst, m_awsize, m_awlen,
        input  m_awready,
        output m_wvalid, m_wdata, m_wstrb, m_wlast,
        input  m_wready,
        input  m_bvalid, m_bresp, m_bid,
        output m_bready
    );

    modport slave (
        output s_valid, s_addr, s_id, s_burst, s_size, s_len, s_wdata, s_wstrb, s_wlast,
        input  s_ready,
        input  s_bvalid, s_bresp, s_bid,
        output s_bready,
        input  m_awvalid, m_awaddr, m_awid, m_awburst, m_awsize, m_awlen,
        output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast,
        output m_wready,
        output m_bvalid, m_bresp, m_bid,
        input  m_bready
    );
endinterface

// File: rtl/axi_write_splitter.sv
// axi_write_splitter: splits a merged write beat stream into AXI4 AW and W
// channels; B is passed straight back upstream. A small W-beat FIFO lets W
// run ahead of AW, and an in-flight counter bounds issued bursts.
//
// Optional macro AXI_SPLIT_LEN_CHECK_EN: burst boundaries come from a beat
// down-counter loaded from s_len instead of from s_wlast; any disagreement
// with s_wlast sets the sticky err_len flag.
//
// state | meaning
// ------+-----------------------------------------------
// FIRST | next accepted beat is a burst head (loads AW)
// BODY  | next accepted beat continues the current burst
module axi_write_splitter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 4,
    parameter int W_FIFO_DEPTH    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_write_splitter_if.master bus,
    output logic [7:0]           outstanding,
    output logic                 err_len
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(W_FIFO_DEPTH);
    localparam int FIFO_W     = DATA_WIDTH + STRB_WIDTH + 1;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic {FIRST = 1'b0, BODY = 1'b1} state_t;

    state_t state, state_next;

    logic s_ready;
    logic accept;
    logic head_accept;
    logic beat_last;
    logic out_ok;
    logic aw_hs;
    logic b_hs;
    logic pop;

    logic                  aw_pending;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [1:0]            aw_burst;
    logic [2:0]            aw_size;
    logic [7:0]            aw_len;

    logic [FIFO_W-1:0] mem [W_FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_head;
    logic [8:0]        inflight;

    assign accept     = bus.s_valid && s_ready;
    assign aw_hs      = aw_pending && bus.m_awready;
    assign b_hs       = bus.m_bvalid && bus.s_bready;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = !fifo_empty && bus.m_wready;
    assign inflight   = {1'b0, outstanding} + {8'd0, aw_pending};
    assign out_ok     = inflight < 9'(MAX_OUTSTANDING);

`ifdef AXI_SPLIT_LEN_CHECK_EN
    // beats still expected after the head; terminal count marks the last beat
    logic [7:0] beats_left;

    assign beat_last = (state == FIRST) ? (bus.s_len == 8'd0) : (beats_left == 8'd1);

    // load remaining-beat count on the head, count down on body beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_left <= 8'd0;
        end else if (head_accept) begin
            beats_left <= bus.s_len;
        end else if (accept) begin
            beats_left <= beats_left - 8'd1;
        end
    end

    // sticky flag when the upstream wlast disagrees with the header length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len <= 1'b0;
        end else if (accept && (bus.s_wlast != beat_last)) begin
            err_len <= 1'b1;
        end
    end
`else
    assign beat_last = bus.s_wlast;
    assign err_len   = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FIRST;
        end else begin
            state <= state_next;
        end
    end

    // next-state: burst boundary follows beat_last
    always_comb begin
        state_next = state;
        case (state)
            FIRST:   if (accept && !beat_last) state_next = BODY;
            BODY:    if (accept && beat_last)  state_next = FIRST;
            default: state_next = FIRST;
        endcase
    end

    // outputs: a head needs a free AW slot and outstanding headroom
    always_comb begin
        s_ready     = 1'b0;
        head_accept = 1'b0;
        case (state)
            FIRST: begin
                s_ready     = !fifo_full && !aw_pending && out_ok;
                head_accept = bus.s_valid && !fifo_full && !aw_pending && out_ok;
            end
            BODY:    s_ready = !fifo_full;
            default: s_ready = 1'b0;
        endcase
    end

    assign bus.s_ready = s_ready;

    // AW holding register, loaded on a head and released by the AW handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_pending <= 1'b0;
            aw_addr    <= '0;
            aw_id      <= '0;
            aw_burst   <= 2'b00;
            aw_size    <= 3'b000;
            aw_len     <= 8'd0;
        end else if (head_accept) begin
            aw_pending <= 1'b1;
            aw_addr    <= bus.s_addr;
            aw_id      <= bus.s_id;
            aw_burst   <= bus.s_burst;
            aw_size    <= bus.s_size;
            aw_len     <= bus.s_len;
        end else if (aw_hs) begin
            aw_pending <= 1'b0;
        end
    end

    assign bus.m_awvalid = aw_pending;
    assign bus.m_awaddr  = aw_addr;
    assign bus.m_awid    = aw_id;
    assign bus.m_awburst = aw_burst;
    assign bus.m_awsize  = aw_size;
    assign bus.m_awlen   = aw_len;

    // W FIFO storage; stale entries are never visible, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[PTR_W-1:0]] <= {beat_last, bus.s_wstrb, bus.s_wdata};
        end
    end

    // W FIFO pointers with wrap bit for full/empty distinction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign fifo_head    = mem[rd_ptr[PTR_W-1:0]];
    assign bus.m_wvalid = !fifo_empty;
    assign bus.m_wdata  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign bus.m_wstrb  = fifo_empty ? '0 : fifo_head[DATA_WIDTH +: STRB_WIDTH];
    assign bus.m_wlast  = fifo_empty ? 1'b0 : fifo_head[FIFO_W-1];

    // in-flight count: +1 per AW, -1 per B, net zero when both coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 8'd0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   outstanding <= outstanding + 8'd1;
                2'b01:   outstanding <= outstanding - 8'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign bus.s_bvalid = bus.m_bvalid;
    assign bus.s_bresp  = bus.m_bresp;
    assign bus.s_bid    = bus.m_bid;
    assign bus.m_bready = bus.s_bready;
endmodule

// File: tb/tb_axi_write_splitter.sv
// Directed bench for axi_write_splitter (default parameters: DEPTH=4, MAX=4).
module tb_axi_write_splitter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] outstanding;
    logic       err_len;

    int tests = 0;
    int fails = 0;
    bit w_toggle = 1'b0;
    int aw_cnt = 0;
    int aw0;
    logic [63:0] wq_data[$];
    logic        wq_last[$];

    always #5 clk = ~clk;

    axi_write_splitter_if bus ();

    axi_write_splitter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .outstanding (outstanding),
        .err_len     (err_len)
    );

    // record W/AW transfers that will complete at the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m_wvalid && bus.m_wready) begin
                wq_data.push_back(bus.m_wdata);
                wq_last.push_back(bus.m_wlast);
            end
            if (bus.m_awvalid && bus.m_awready) aw_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (w_toggle) bus.m_wready = ~bus.m_wready;
    endtask

    task automatic set_beat(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [63:0] data, input logic last);
        bus.s_valid = 1'b1;
        bus.s_addr  = addr;
        bus.s_id    = id;
        bus.s_burst = 2'b01;
        bus.s_size  = 3'd3;
        bus.s_len   = len;
        bus.s_wdata = data;
        bus.s_wstrb = 8'hFF;
        bus.s_wlast = last;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.s_ready && n < 50) begin
            tick();
            n++;
        end
        chk("s_ready_wait", bus.s_ready, 1);
    endtask

    task automatic send_beat(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [63:0] data, input logic last);
        set_beat(addr, id, len, data, last);
        wait_ready();
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_w(input int n);
        int k = 0;
        while (wq_data.size() < n && k < 60) begin
            tick();
            k++;
        end
        chk("w_beat_count", wq_data.size(), n);
    endtask

    task automatic b_resp(input logic [3:0] id);
        bus.m_bvalid = 1'b1;
        bus.m_bid    = id;
        bus.m_bresp  = 2'b00;
        bus.s_bready = 1'b1;
        tick();
        bus.m_bvalid = 1'b0;
        bus.s_bready = 1'b0;
    endtask

    task automatic clear_q();
        wq_data.delete();
        wq_last.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_addr = '0; bus.s_id = '0; bus.s_burst = '0;
        bus.s_size = '0; bus.s_len = '0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 1'b0;
        bus.s_bready = 1'b0; bus.m_awready = 1'b0; bus.m_wready = 1'b0;
        bus.m_bvalid = 1'b0; bus.m_bresp = '0; bus.m_bid = '0;

        // reset state
        tick(); tick();
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_awvalid", bus.m_awvalid, 0);
        chk("rst_wvalid", bus.m_wvalid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_awaddr", bus.m_awaddr, 0);
        chk("rst_wdata", bus.m_wdata, 0);
        rst_n = 1'b1;
        tick();

        // single beat burst, B returns it
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        set_beat(32'h1000, 4'd3, 8'd0, 64'hA1, 1'b1);
        chk("t1_s_ready", bus.s_ready, 1);
        tick();
        bus.s_valid = 1'b0;
        chk("t1_awvalid", bus.m_awvalid, 1);
        chk("t1_awaddr", bus.m_awaddr, 64'h1000);
        chk("t1_awid", bus.m_awid, 3);
        chk("t1_awlen", bus.m_awlen, 0);
        chk("t1_wvalid", bus.m_wvalid, 1);
        chk("t1_wdata", bus.m_wdata, 64'hA1);
        chk("t1_wlast", bus.m_wlast, 1);
        chk("t1_out_before", outstanding, 0);
        tick();
        chk("t1_awvalid_done", bus.m_awvalid, 0);
        chk("t1_wvalid_done", bus.m_wvalid, 0);
        chk("t1_out_one", outstanding, 1);
        bus.m_bvalid = 1'b1; bus.m_bid = 4'd3; bus.m_bresp = 2'b00; bus.s_bready = 1'b1;
        #1;
        chk("t1_s_bvalid", bus.s_bvalid, 1);
        chk("t1_s_bid", bus.s_bid, 3);
        chk("t1_s_bresp", bus.s_bresp, 0);
        chk("t1_m_bready", bus.m_bready, 1);
        tick();
        bus.m_bvalid = 1'b0; bus.s_bready = 1'b0;
        chk("t1_out_zero", outstanding, 0);

        // 4-beat burst with toggling W ready
        clear_q();
        aw0 = aw_cnt;
        w_toggle = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(32'h2000, 4'd5, 8'd3, 64'h20 + 64'(i), i == 3);
        wait_w(4);
        w_toggle = 1'b0;
        bus.m_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < wq_data.size()) begin
                chk("t2_wdata", wq_data[i], 64'h20 + 64'(i));
                chk("t2_wlast", wq_last[i], i == 3);
            end
        end
        tick();
        chk("t2_aw_count", aw_cnt - aw0, 1);
        chk("t2_out", outstanding, 1);
        b_resp(4'd5);
        chk("t2_out_zero", outstanding, 0);

        // AW held off: all W drains first, second head refused
        clear_q();
        aw0 = aw_cnt;
        bus.m_awready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(32'h3000, 4'd6, 8'd7, 64'h30 + 64'(i), i == 7);
        wait_w(8);
        for (int i = 0; i < 8; i++) begin
            if (i < wq_data.size()) begin
                chk("t3_wdata", wq_data[i], 64'h30 + 64'(i));
                chk("t3_wlast", wq_last[i], i == 7);
            end
        end
        chk("t3_no_aw", aw_cnt - aw0, 0);
        chk("t3_awvalid_held", bus.m_awvalid, 1);
        set_beat(32'h3100, 4'd7, 8'd0, 64'h3F, 1'b1);
        chk("t3_head_refused", bus.s_ready, 0);
        tick(); tick();
        chk("t3_head_refused2", bus.s_ready, 0);
        chk("t3_no_extra_w", wq_data.size(), 8);
        bus.m_awready = 1'b1;
        tick();
        chk("t3_out_one", outstanding, 1);
        chk("t3_ready_after_aw", bus.s_ready, 1);
        tick();
        bus.s_valid = 1'b0;
        chk("t3_aw2_valid", bus.m_awvalid, 1);
        chk("t3_aw2_addr", bus.m_awaddr, 64'h3100);
        tick();
        chk("t3_out_two", outstanding, 2);
        wait_w(9);
        if (wq_data.size() > 8) chk("t3_w2_data", wq_data[8], 64'h3F);
        b_resp(4'd6);
        b_resp(4'd7);
        chk("t3_out_zero", outstanding, 0);

        // W stalled: FIFO fills after 4 beats, ready returns after first pop
        clear_q();
        bus.m_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_beat(32'h4000, 4'd8, 8'd7, 64'h40 + 64'(i), 1'b0);
            tick();
        end
        chk("t4_full_ready", bus.s_ready, 0);
        set_beat(32'h4000, 4'd8, 8'd7, 64'h44, 1'b0);
        tick(); tick();
        chk("t4_still_full", bus.s_ready, 0);
        chk("t4_no_w", wq_data.size(), 0);
        bus.m_wready = 1'b1;
        tick();
        chk("t4_ready_after_pop", bus.s_ready, 1);
        for (int i = 4; i < 8; i++) send_beat(32'h4000, 4'd8, 8'd7, 64'h40 + 64'(i), i == 7);
        wait_w(8);
        for (int i = 0; i < 8; i++) begin
            if (i < wq_data.size()) begin
                chk("t4_wdata", wq_data[i], 64'h40 + 64'(i));
                chk("t4_wlast", wq_last[i], i == 7);
            end
        end
        chk("t4_out", outstanding, 1);
        b_resp(4'd8);
        chk("t4_out_zero", outstanding, 0);

        // outstanding limit and simultaneous AW/B
        for (int i = 0; i < 4; i++) send_beat(32'h5000 + 32'(i * 16), 4'(i), 8'd0, 64'h50 + 64'(i), 1'b1);
        tick(); tick();
        chk("t5_out_max", outstanding, 4);
        set_beat(32'h5040, 4'd4, 8'd0, 64'h54, 1'b1);
        tick(); tick();
        chk("t5_head_blocked", bus.s_ready, 0);
        chk("t5_no_aw", bus.m_awvalid, 0);
        bus.m_bvalid = 1'b1; bus.m_bid = 4'd0; bus.s_bready = 1'b1;
        tick();
        bus.m_bvalid = 1'b0;
        chk("t5_out_three", outstanding, 3);
        chk("t5_ready_again", bus.s_ready, 1);
        tick();
        bus.s_valid = 1'b0;
        chk("t5_aw5_valid", bus.m_awvalid, 1);
        bus.m_bvalid = 1'b1; bus.m_bid = 4'd1;
        tick();
        bus.m_bvalid = 1'b0; bus.s_bready = 1'b0;
        chk("t5_aw_b_same", outstanding, 3);
        chk("t5_aw5_done", bus.m_awvalid, 0);
        b_resp(4'd2); b_resp(4'd3); b_resp(4'd4);
        chk("t5_out_zero", outstanding, 0);
        tick(); tick();
        clear_q();

        // length check option
        aw0 = aw_cnt;
`ifdef AXI_SPLIT_LEN_CHECK_EN
        for (int i = 0; i < 4; i++) send_beat(32'h6000, 4'd2, 8'd3, 64'h60 + 64'(i), i == 1);
        wait_w(4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq_last.size()) chk("t6_wlast_cnt", wq_last[i], i == 3);
        end
        chk("t6_err_set", err_len, 1);
        tick(); tick();
        chk("t6_err_sticky", err_len, 1);
        chk("t6_aw_count", aw_cnt - aw0, 1);
        b_resp(4'd2);
`else
        send_beat(32'h6000, 4'd2, 8'd3, 64'h60, 1'b0);
        send_beat(32'h6000, 4'd2, 8'd3, 64'h61, 1'b1);
        send_beat(32'h6100, 4'd2, 8'd0, 64'h62, 1'b1);
        wait_w(3);
        for (int i = 0; i < 3; i++) begin
            if (i < wq_last.size()) chk("t6_wlast_pass", wq_last[i], i != 0);
        end
        tick(); tick();
        chk("t6_err_tied", err_len, 0);
        chk("t6_aw_count", aw_cnt - aw0, 2);
        b_resp(4'd2);
        b_resp(4'd2);
`endif
        chk("t6_out_zero", outstanding, 0);

        // reset mid-burst
        send_beat(32'h7000, 4'd9, 8'd0, 64'h70, 1'b1);
        tick(); tick();
        chk("t7_out_pre", outstanding, 1);
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        send_beat(32'h7080, 4'd9, 8'd3, 64'h71, 1'b0);
        send_beat(32'h7080, 4'd9, 8'd3, 64'h72, 1'b0);
        chk("t7_awvalid_pre", bus.m_awvalid, 1);
        chk("t7_wvalid_pre", bus.m_wvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_awvalid", bus.m_awvalid, 0);
        chk("t7_wvalid", bus.m_wvalid, 0);
        chk("t7_out", outstanding, 0);
        chk("t7_err", err_len, 0);
        chk("t7_s_ready", bus.s_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        clear_q();
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        send_beat(32'h7100, 4'd10, 8'd0, 64'h7A, 1'b1);
        chk("t7_new_head", bus.m_awvalid, 1);
        chk("t7_new_addr", bus.m_awaddr, 64'h7100);
        tick();
        chk("t7_out_after", outstanding, 1);
        wait_w(1);
        if (wq_data.size() > 0) chk("t7_w_fresh", wq_data[0], 64'h7A);
        b_resp(4'd10);
        chk("t7_out_zero", outstanding, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
